bus_adr_qualifier: RTL and testbench

Parametrised CPU address qualifier/latch for the T35 SBC. It sits between the raw CPU address pins and the S100-side address drivers. It synchronises the asynchronous CPU status strobes (sMEMR, sMWRT, sOUT, sINP) into the pll0_250MHz domain and captures the address in step with them. It holds a stable, qualified address for the whole bus cycle plus a programmable hold time, and applies a selectable high-byte policy on I/O cycles (zero, pass-through, or mirror).

---
 rtl/bus_pkg.sv | 31 +++
 rtl/bus_adr_qualifier_if.sv | 26 ++
 rtl/bus_adr_qualifier_sync_chain.sv | 23 ++
 rtl/bus_adr_qualifier.sv | 135 +++++++++++++
 tb/tb_bus_adr_qualifier.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared cycle-type encodings, I/O high-byte policies and strobe helpers
package bus_pkg;

  localparam logic [1:0] CYC_MEMR = 2'd0;
  localparam logic [1:0] CYC_MWRT = 2'd1;
  localparam logic [1:0] CYC_OUT  = 2'd2;
  localparam logic [1:0] CYC_INP  = 2'd3;

  localparam int IOHI_ZERO   = 0;
  localparam int IOHI_PASS   = 1;
  localparam int IOHI_MIRROR = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HOLD
  } adrState_t;

  // Strobe vectors are indexed by cycle type: [0]=MEMR [1]=MWRT [2]=OUT [3]=INP
  function automatic logic [1:0] strobePick(input logic [3:0] stb);
    if (stb[CYC_INP])       return CYC_INP;
    else if (stb[CYC_OUT])  return CYC_OUT;
    else if (stb[CYC_MEMR]) return CYC_MEMR;
    else                    return CYC_MWRT;
  endfunction

  function automatic logic multiStrobe(input logic [3:0] stb);
    return ($countones(stb) > 1);
  endfunction

endpackage

// File: rtl/bus_adr_qualifier_if.sv
// rtl/bus_adr_qualifier_if.sv - CPU-pin side and qualified-address side of the address qualifier
interface bus_adr_qualifier_if #(
  parameter int ADR_W = 16
);
  logic [ADR_W-1:0] cpuAdr;
  logic             sMEMR;
  logic             sMWRT;
  logic             sOUT;
  logic             sINP;
  logic [ADR_W-1:0] adrOut;
  logic [1:0]       cycType;
  logic             adrValid;
  logic             cycStart;
  logic             cycEnd;
  logic             protoErr;

  modport master (
    output cpuAdr, sMEMR, sMWRT, sOUT, sINP,
    input  adrOut, cycType, adrValid, cycStart, cycEnd, protoErr
  );

  modport slave (
    input  cpuAdr, sMEMR, sMWRT, sOUT, sINP,
    output adrOut, cycType, adrValid, cycStart, cycEnd, protoErr
  );
endinterface

// File: rtl/bus_adr_qualifier_sync_chain.sv
// rtl/bus_adr_qualifier_sync_chain.sv - flop chain used to bring async strobes and address into the clock domain
module sync_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];
endmodule

// File: rtl/bus_adr_qualifier.sv
// rtl/bus_adr_qualifier.sv - CPU address qualifier: strobe sync, capture FSM, hold timer, I/O high-byte policy
module bus_adr_qualifier
  import bus_pkg::*;
#(
  parameter int ADR_W       = 16,
  parameter int IO_ADR_W    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IO_HI_MODE  = IOHI_ZERO,
  parameter int HOLD_MIN    = 2
) (
  input logic                pll0_250MHz,
  input logic                reset,
  bus_adr_qualifier_if.slave bus
);
  localparam int HI_W  = ADR_W - IO_ADR_W;
  localparam int CNT_W = (HOLD_MIN > 1) ? $clog2(HOLD_MIN) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_MIN > 0) ? CNT_W'(HOLD_MIN - 1) : '0;

  logic [3:0]       syncStb;
  logic [ADR_W-1:0] syncAdr;
  logic [ADR_W-1:0] ioAdr;
  logic [ADR_W-1:0] capAdr;
  logic [1:0]       selType;
  logic             sAny;

  adrState_t        state;
  logic [CNT_W-1:0] holdCnt;
  logic [ADR_W-1:0] adrOutR;
  logic [1:0]       cycTypeR;
  logic             adrValidR;
  logic             cycStartR;
  logic             cycEndR;
  logic             protoErrR;

  // Address goes through the same depth as the strobes so both line up at capture
  sync_chain #(.WIDTH(4), .DEPTH(SYNC_STAGES)) uStbSync (
    .clk   (pll0_250MHz),
    .reset (reset),
    .d     ({bus.sINP, bus.sOUT, bus.sMWRT, bus.sMEMR}),
    .q     (syncStb)
  );

  sync_chain #(.WIDTH(ADR_W), .DEPTH(SYNC_STAGES)) uAdrSync (
    .clk   (pll0_250MHz),
    .reset (reset),
    .d     (bus.cpuAdr),
    .q     (syncAdr)
  );

  generate
    if (HI_W == 0) begin : gNoHi
      assign ioAdr = syncAdr;
    end else begin : gHi
      logic [HI_W-1:0] hiBits;
      if (IO_HI_MODE == IOHI_PASS) begin : gPass
        assign hiBits = syncAdr[ADR_W-1:IO_ADR_W];
      end else if (IO_HI_MODE == IOHI_MIRROR && ADR_W == 2 * IO_ADR_W) begin : gMirror
        assign hiBits = syncAdr[IO_ADR_W-1:0];
      end else begin : gZero
        assign hiBits = '0;
      end
      assign ioAdr = {hiBits, syncAdr[IO_ADR_W-1:0]};
    end
  endgenerate

  assign sAny    = |syncStb;
  assign selType = strobePick(syncStb);
  assign capAdr  = (selType >= CYC_OUT) ? ioAdr : syncAdr;

  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      state     <= ST_IDLE;
      holdCnt   <= '0;
      adrOutR   <= '0;
      cycTypeR  <= CYC_MEMR;
      adrValidR <= 1'b0;
      cycStartR <= 1'b0;
      cycEndR   <= 1'b0;
      protoErrR <= 1'b0;
    end else begin
      cycStartR <= 1'b0;
      cycEndR   <= 1'b0;
      protoErrR <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (sAny) begin
            adrOutR   <= capAdr;
            cycTypeR  <= selType;
            adrValidR <= 1'b1;
            cycStartR <= 1'b1;
            protoErrR <= multiStrobe(syncStb);
            state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Only the strobe that won capture ends the cycle
          if (!syncStb[cycTypeR]) begin
            if (HOLD_MIN == 0) begin
              adrValidR <= 1'b0;
              cycEndR   <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              holdCnt <= HOLD_LOAD;
              state   <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (sAny) begin
            adrOutR   <= capAdr;
            cycTypeR  <= selType;
            cycStartR <= 1'b1;
            cycEndR   <= 1'b1;
            protoErrR <= multiStrobe(syncStb);
            state     <= ST_ACTIVE;
          end else if (holdCnt == '0) begin
            adrValidR <= 1'b0;
            cycEndR   <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.adrOut   = adrOutR;
  assign bus.cycType  = cycTypeR;
  assign bus.adrValid = adrValidR;
  assign bus.cycStart = cycStartR;
  assign bus.cycEnd   = cycEndR;
  assign bus.protoErr = protoErrR;
endmodule

// File: tb/tb_bus_adr_qualifier.sv
// tb/tb_bus_adr_qualifier.sv - three-configuration bench for bus_adr_qualifier against a cycle-level reference model
module tb_bus_adr_qualifier;
  import bus_pkg::*;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pStb;
  logic [15:0] pAdr;
  int          checks;
  int          failures;

  always #2 clk = ~clk;

  // dut0: defaults; dut1: pass-through, hold 1, 3-stage sync; dut2: mirror, hold 0
  function automatic int syncOf(input int d);
    return (d == 1) ? 3 : 2;
  endfunction
  function automatic int holdOf(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 0;
  endfunction
  function automatic int modeOf(input int d);
    return d;
  endfunction

  bus_adr_qualifier_if #(.ADR_W(16)) bus0 ();
  bus_adr_qualifier_if #(.ADR_W(16)) bus1 ();
  bus_adr_qualifier_if #(.ADR_W(16)) bus2 ();

  assign bus0.cpuAdr = pAdr;
  assign bus0.sMEMR = pStb[0];
  assign bus0.sMWRT = pStb[1];
  assign bus0.sOUT = pStb[2];
  assign bus0.sINP = pStb[3];
  assign bus1.cpuAdr = pAdr;
  assign bus1.sMEMR = pStb[0];
  assign bus1.sMWRT = pStb[1];
  assign bus1.sOUT = pStb[2];
  assign bus1.sINP = pStb[3];
  assign bus2.cpuAdr = pAdr;
  assign bus2.sMEMR = pStb[0];
  assign bus2.sMWRT = pStb[1];
  assign bus2.sOUT = pStb[2];
  assign bus2.sINP = pStb[3];

  bus_adr_qualifier #(.ADR_W(16), .IO_ADR_W(8), .SYNC_STAGES(2), .IO_HI_MODE(0), .HOLD_MIN(2)) dut0 (
    .pll0_250MHz (clk), .reset (reset), .bus (bus0));
  bus_adr_qualifier #(.ADR_W(16), .IO_ADR_W(8), .SYNC_STAGES(3), .IO_HI_MODE(1), .HOLD_MIN(1)) dut1 (
    .pll0_250MHz (clk), .reset (reset), .bus (bus1));
  bus_adr_qualifier #(.ADR_W(16), .IO_ADR_W(8), .SYNC_STAGES(2), .IO_HI_MODE(2), .HOLD_MIN(0)) dut2 (
    .pll0_250MHz (clk), .reset (reset), .bus (bus2));

  logic [21:0] obs [ND];
  always_comb begin
    obs[0] = {bus0.adrOut, bus0.cycType, bus0.adrValid, bus0.cycStart, bus0.cycEnd, bus0.protoErr};
    obs[1] = {bus1.adrOut, bus1.cycType, bus1.adrValid, bus1.cycStart, bus1.cycEnd, bus1.protoErr};
    obs[2] = {bus2.adrOut, bus2.cycType, bus2.adrValid, bus2.cycStart, bus2.cycEnd, bus2.protoErr};
  end

  // Reference model: pin history, then per-DUT cycle bookkeeping
  function automatic logic [1:0] prioRef(input logic [3:0] s);
    int order [4] = '{3, 2, 0, 1};
    for (int i = 0; i < 4; i++) if (s[order[i]]) return 2'(order[i]);
    return 2'd0;
  endfunction

  function automatic logic [15:0] xfRef(input logic [15:0] a, input logic [1:0] typ, input int mode);
    int lo;
    if (typ < 2) return a;
    lo = int'(a) % 256;
    if (mode == 1) return a;
    if (mode == 2) return 16'(lo * 257);
    return 16'(lo);
  endfunction

  logic [3:0]  hStb [4];
  logic [15:0] hAdr [4];
  logic [15:0] eAdr [ND];
  logic [1:0]  eTyp [ND];
  logic        eValid [ND];
  logic        eStart [ND];
  logic        eEnd [ND];
  logic        eErr [ND];
  logic        eRel [ND];
  int          eLeft [ND];
  logic [15:0] nAdr [ND];
  logic [1:0]  nTyp [ND];
  logic        nValid [ND];
  logic        nStart [ND];
  logic        nEnd [ND];
  logic        nErr [ND];
  logic        nRel [ND];
  int          nLeft [ND];
  logic [21:0] expv [ND];

  always_comb begin : modelNext
    logic [3:0]  s;
    logic [15:0] a;
    logic        cap;
    int          ones;
    for (int d = 0; d < ND; d++) begin
      s = hStb[syncOf(d)-1];
      a = hAdr[syncOf(d)-1];
      cap = 1'b0;
      ones = 0;
      nAdr[d] = eAdr[d];
      nTyp[d] = eTyp[d];
      nValid[d] = eValid[d];
      nStart[d] = 1'b0;
      nEnd[d] = 1'b0;
      nErr[d] = 1'b0;
      nRel[d] = eRel[d];
      nLeft[d] = eLeft[d];
      if (!eValid[d]) begin
        cap = |s;
      end else if (!eRel[d]) begin
        if (!s[eTyp[d]]) begin
          if (holdOf(d) == 0) begin
            nValid[d] = 1'b0;
            nEnd[d] = 1'b1;
          end else begin
            nRel[d] = 1'b1;
            nLeft[d] = holdOf(d);
          end
        end
      end else if (|s) begin
        nEnd[d] = 1'b1;
        cap = 1'b1;
      end else begin
        nLeft[d] = eLeft[d] - 1;
        if (nLeft[d] == 0) begin
          nValid[d] = 1'b0;
          nEnd[d] = 1'b1;
          nRel[d] = 1'b0;
        end
      end
      if (cap) begin
        for (int b = 0; b < 4; b++) ones += int'(s[b]);
        nValid[d] = 1'b1;
        nStart[d] = 1'b1;
        nRel[d] = 1'b0;
        nTyp[d] = prioRef(s);
        nAdr[d] = xfRef(a, prioRef(s), modeOf(d));
        nErr[d] = (ones > 1);
      end
      expv[d] = {eAdr[d], eTyp[d], eValid[d], eStart[d], eEnd[d], eErr[d]};
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hStb[i] <= '0;
        hAdr[i] <= '0;
      end
      for (int d = 0; d < ND; d++) begin
        eAdr[d] <= '0; eTyp[d] <= '0; eValid[d] <= 1'b0; eStart[d] <= 1'b0;
        eEnd[d] <= 1'b0; eErr[d] <= 1'b0; eRel[d] <= 1'b0; eLeft[d] <= 0;
      end
    end else begin
      hStb[0] <= pStb;
      hAdr[0] <= pAdr;
      for (int i = 1; i < 4; i++) begin
        hStb[i] <= hStb[i-1];
        hAdr[i] <= hAdr[i-1];
      end
      for (int d = 0; d < ND; d++) begin
        eAdr[d] <= nAdr[d]; eTyp[d] <= nTyp[d]; eValid[d] <= nValid[d]; eStart[d] <= nStart[d];
        eEnd[d] <= nEnd[d]; eErr[d] <= nErr[d]; eRel[d] <= nRel[d]; eLeft[d] <= nLeft[d];
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== 22'h0) begin
          failures++;
          $display("FAIL reset_state dut%0d cycle%0d got=%h exp=%h", d, k, obs[d], 22'h0);
        end
      end
      if (k == 3) reset = 1'b0;
    end
  endtask

  task automatic test_io_inp();
    int startAt = -1;
    int endAt = -1;
    pAdr = 16'hA53C;
    pStb = 4'b1000;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv[d]) begin
          failures++;
          $display("FAIL io_inp dut%0d cycle%0d got=%h exp=%h", d, k, obs[d], expv[d]);
        end
      end
      if (bus0.cycStart && startAt < 0) begin
        startAt = k;
        checks++;
        if (bus0.adrOut !== 16'h003C || bus0.cycType !== 2'd3) begin
          failures++;
          $display("FAIL io_inp_capture got=%h/%0d exp=003c/3", bus0.adrOut, bus0.cycType);
        end
      end
      if (bus0.cycEnd && endAt < 0) endAt = k;
      if (k == 6) pStb = 4'b0000;
    end
    checks++;
    if (startAt != 3) begin
      failures++;
      $display("FAIL io_inp_latency got=%0d exp=3", startAt);
    end
    checks++;
    if (endAt != 11) begin
      failures++;
      $display("FAIL io_inp_hold got=%0d exp=11", endAt);
    end
  endtask

  task automatic test_io_hi_modes();
    pAdr = 16'h1234;
    pStb = 4'b0100;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv[d]) begin
          failures++;
          $display("FAIL io_hi dut%0d cycle%0d got=%h exp=%h", d, k, obs[d], expv[d]);
        end
      end
      if (k == 5) begin
        checks++;
        if (bus0.adrOut !== 16'h0034 || bus1.adrOut !== 16'h1234 || bus2.adrOut !== 16'h3434) begin
          failures++;
          $display("FAIL io_hi_policy got=%h/%h/%h exp=0034/1234/3434", bus0.adrOut, bus1.adrOut, bus2.adrOut);
        end
        checks++;
        if (bus0.cycType !== 2'd2 || bus1.cycType !== 2'd2 || bus2.cycType !== 2'd2) begin
          failures++;
          $display("FAIL io_hi_type got=%0d/%0d/%0d exp=2", bus0.cycType, bus1.cycType, bus2.cycType);
        end
      end
      if (k == 6) pStb = 4'b0000;
    end
  endtask

  task automatic test_memr_full();
    int endAt = -1;
    pAdr = 16'hFFFF;
    pStb = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv[d]) begin
          failures++;
          $display("FAIL memr dut%0d cycle%0d got=%h exp=%h", d, k, obs[d], expv[d]);
        end
      end
      if (k == 4) begin
        checks++;
        if (bus2.adrOut !== 16'hFFFF || bus2.cycType !== 2'd0 || bus0.adrOut !== 16'hFFFF) begin
          failures++;
          $display("FAIL memr_capture got=%h/%0d/%h exp=ffff/0/ffff", bus2.adrOut, bus2.cycType, bus0.adrOut);
        end
      end
      if (bus2.cycEnd && endAt < 0) begin
        endAt = k;
        checks++;
        if (bus2.adrValid !== 1'b0) begin
          failures++;
          $display("FAIL memr_valid_drop got=%b exp=0", bus2.adrValid);
        end
      end
      if (k == 5) pStb = 4'b0000;
    end
    checks++;
    if (endAt != 8) begin
      failures++;
      $display("FAIL memr_hold0 got=%0d exp=8", endAt);
    end
  endtask

  task automatic test_multi_strobe();
    int errCnt = 0;
    int startCnt = 0;
    pAdr = 16'h5A5A;
    pStb = 4'b0101;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv[d]) begin
          failures++;
          $display("FAIL multi dut%0d cycle%0d got=%h exp=%h", d, k, obs[d], expv[d]);
        end
      end
      errCnt += int'(bus0.protoErr);
      startCnt += int'(bus0.cycStart);
      if (k == 3) begin
        checks++;
        if (bus0.cycType !== 2'd2) begin
          failures++;
          $display("FAIL multi_priority got=%0d exp=2", bus0.cycType);
        end
      end
      if (k == 9) begin
        checks++;
        if (bus0.adrValid !== 1'b1) begin
          failures++;
          $display("FAIL multi_ignore_memr got=%b exp=1", bus0.adrValid);
        end
      end
      if (k == 4) pStb = 4'b0100;
      if (k == 9) pStb = 4'b0000;
    end
    checks++;
    if (errCnt != 1 || startCnt != 1) begin
      failures++;
      $display("FAIL multi_counts got=err%0d/start%0d exp=err1/start1", errCnt, startCnt);
    end
  endtask

  task automatic test_back_to_back();
    int both = 0;
    int ends = 0;
    int gaps = 0;
    logic begun = 1'b0;
    pAdr = 16'h0100;
    pStb = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv[d]) begin
          failures++;
          $display("FAIL b2b dut%0d cycle%0d got=%h exp=%h", d, k, obs[d], expv[d]);
        end
      end
      if (bus0.cycStart) begin_flag(begun);
      if (bus0.cycStart && bus0.cycEnd) both++;
      if (bus0.cycEnd && !bus0.cycStart) ends++;
      if (begun && ends == 0 && !bus0.adrValid) gaps++;
      if (k == 5) pStb = 4'b0000;
      if (k == 6) begin
        pStb = 4'b0001;
        pAdr = 16'h0200;
      end
      if (k == 11) pStb = 4'b0000;
    end
    checks++;
    if (both != 1 || ends != 1 || gaps != 0) begin
      failures++;
      $display("FAIL b2b_pulses got=both%0d/ends%0d/gaps%0d exp=both1/ends1/gaps0", both, ends, gaps);
    end
    checks++;
    if (bus0.adrOut !== 16'h0200 || bus0.cycType !== 2'd0 || bus0.adrValid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_final got=%h/%0d/%b exp=0200/0/0", bus0.adrOut, bus0.cycType, bus0.adrValid);
    end
  endtask

  task automatic begin_flag(output logic flag);
    flag = 1'b1;
  endtask

  task automatic test_reset_active();
    int start0 = -1;
    int start1 = -1;
    pAdr = 16'hBEEF;
    pStb = 4'b1000;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv[d]) begin
          failures++;
          $display("FAIL rst_active dut%0d cycle%0d got=%h exp=%h", d, k, obs[d], expv[d]);
        end
        if (k == 6) begin
          checks++;
          if (obs[d] !== 22'h0) begin
            failures++;
            $display("FAIL rst_abort dut%0d got=%h exp=%h", d, obs[d], 22'h0);
          end
        end
      end
      if (k > 7 && bus0.cycStart && start0 < 0) begin
        start0 = k;
        checks++;
        if (bus0.adrOut !== 16'h00EF) begin
          failures++;
          $display("FAIL rst_recapture got=%h exp=00ef", bus0.adrOut);
        end
      end
      if (k > 7 && bus1.cycStart && start1 < 0) start1 = k;
      if (k == 5) reset = 1'b1;
      if (k == 7) reset = 1'b0;
      if (k == 13) pStb = 4'b0000;
    end
    checks++;
    if (start0 != 10 || start1 != 11) begin
      failures++;
      $display("FAIL rst_relatency got=%0d/%0d exp=10/11", start0, start1);
    end
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv[d]) begin
          failures++;
          $display("FAIL random dut%0d cycle%0d got=%h exp=%h", d, k, obs[d], expv[d]);
        end
      end
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 50) pStb = 4'b0000;
        else if (r < 85) pStb = 4'(1 << $urandom_range(0, 3));
        else pStb = 4'($urandom);
      end
      pAdr = 16'($urandom);
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    pStb = 4'b0000;
    pAdr = 16'h0000;
    test_reset();
    test_io_inp();
    test_io_hi_modes();
    test_memr_full();
    test_multi_strobe();
    test_back_to_back();
    test_reset_active();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
